// File: rtl/fp8_multiply.sv
// Sequential FP8 (1-3-4, bias 3) multiplier: start-edge launch, 5-step shift-add mantissa
// multiply, normalise, pack; done holds with the result until the next launch.
module fp8_multiply #(
  parameter int unsigned MUL_STEPS = 5,
  parameter int unsigned BIAS      = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] product,
  output logic       done
);

  localparam int unsigned ACC_W  = 10;
  localparam int unsigned EXP_W  = 6;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned FRAC_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    PACK = 2'd3
  } state_e;

  state_e                  state_q;
  logic                    start_d_q;
  logic                    sign_q;
  logic signed [EXP_W-1:0] exp_sum_q;
  logic                    zero_q;
  logic [ACC_W-1:0]        mcand_q;
  logic [MUL_STEPS-1:0]    mplier_q;
  logic [ACC_W-1:0]        acc_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [FRAC_W-1:0]       frac_q;
  logic [7:0]              product_q;
  logic                    done_q;

  assign product = product_q;
  assign done    = done_q;

  // Launch only on a synchronously detected rising edge of start while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      start_d_q <= 1'b0;
      sign_q    <= 1'b0;
      exp_sum_q <= '0;
      zero_q    <= 1'b0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      frac_q    <= '0;
      product_q <= 8'h00;
      done_q    <= 1'b0;
    end else begin
      start_d_q <= start;
      unique case (state_q)
        IDLE: begin
          if (start && !start_d_q) begin
            done_q    <= 1'b0;
            sign_q    <= a[7] ^ b[7];
            exp_sum_q <= EXP_W'({3'b000, a[6:4]}) + EXP_W'({3'b000, b[6:4]}) - EXP_W'(BIAS);
            zero_q    <= (a[6:4] == 3'd0) || (b[6:4] == 3'd0);
            mcand_q   <= ACC_W'({1'b1, a[3:0]});
            mplier_q  <= {1'b1, b[3:0]};
            acc_q     <= '0;
            cnt_q     <= '0;
            state_q   <= MUL;
          end
        end
        // Multiplicand walks left while the multiplier is consumed LSB first
        MUL: begin
          if (mplier_q[0]) begin
            acc_q <= acc_q + mcand_q;
          end
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(MUL_STEPS - 1)) begin
            state_q <= NORM;
          end
        end
        // Product lies in [1,4) with the binary point after bit 8; truncate to 4 frac bits
        NORM: begin
          if (acc_q[9]) begin
            frac_q    <= acc_q[8:5];
            exp_sum_q <= exp_sum_q + EXP_W'(1);
          end else begin
            frac_q    <= acc_q[7:4];
          end
          state_q <= PACK;
        end
        PACK: begin
          if (zero_q || (exp_sum_q < 6'sd1)) begin
            product_q <= 8'h00;
          end else if (exp_sum_q > 6'sd7) begin
            product_q <= {sign_q, 7'h7F};
          end else begin
            product_q <= {sign_q, exp_sum_q[2:0], frac_q};
          end
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp8_multiply.sv
// Self-checking bench for fp8_multiply: directed vector table, handshake/reset sequences,
// and randomized operands against a real-arithmetic reference model.
module tb_fp8_multiply;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] product;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;

  fp8_multiply dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .product (product),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference: value-level arithmetic on the decoded operands
  function automatic logic [7:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
    int  ex;
    int  ey;
    int  e;
    int  f;
    real v;
    logic s;
    ex = int'(x[6:4]);
    ey = int'(y[6:4]);
    s  = x[7] ^ y[7];
    if (ex == 0 || ey == 0) return 8'h00;
    v = (1.0 + real'(x[3:0]) / 16.0) * (1.0 + real'(y[3:0]) / 16.0);
    e = ex + ey - 3;
    while (v >= 2.0) begin
      v = v / 2.0;
      e++;
    end
    f = int'($floor((v - 1.0) * 16.0));
    if (e < 1) return 8'h00;
    if (e > 7) return {s, 7'h7F};
    return {s, 3'(e), 4'(f)};
  endfunction

  // Returns just after the launch edge
  task automatic launch(input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts edges after launch until done; 0 means timeout
  task automatic wait_done(input string name, output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) @(posedge clk);
      else @(posedge clk);
      #1;
      if (k == 1) check({name, "_done_low"}, 32'(done), 32'd0);
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_op(input string name, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] req);
    int lat;
    launch(x, y);
    wait_done(name, lat);
    check({name, "_latency"}, 32'(lat), 32'd7);
    check({name, "_product"}, 32'(product), 32'(req));
  endtask

  vec_t vecs[8];

  initial begin
    int lat;
    int rises;
    int falls;
    logic prev;
    logic [7:0] ra;
    logic [7:0] rb;

    vecs[0] = '{8'h30, 8'h30, 8'h30};
    vecs[1] = '{8'h38, 8'h38, 8'h42};
    vecs[2] = '{8'hC0, 8'h48, 8'hD8};
    vecs[3] = '{8'h7F, 8'h7F, 8'h7F};
    vecs[4] = '{8'hFF, 8'h7F, 8'hFF};
    vecs[5] = '{8'h00, 8'h48, 8'h00};
    vecs[6] = '{8'h8F, 8'h38, 8'h00};
    vecs[7] = '{8'h10, 8'h10, 8'h00};

    rst_n = 1'b0;
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_product", 32'(product), 32'h00);
    check("reset_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp);
    end

    // Second start pulse mid-operation with new operands must be ignored
    launch(8'h38, 8'h38);
    @(posedge clk); #1;
    check("restart_done_low_e1", 32'(done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    a = 8'h7F;
    b = 8'h7F;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    for (int k = 4; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    check("restart_latency", 32'(lat), 32'd7);
    check("restart_product", 32'(product), 32'h42);
    falls = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (!done) falls++;
    end
    check("restart_no_second_op", 32'(falls), 32'd0);

    // Held start produces a single operation
    @(negedge clk);
    a = 8'hC0;
    b = 8'h48;
    start = 1'b1;
    rises = 0;
    falls = 0;
    prev = done;
    for (int k = 0; k < 32; k++) begin
      @(posedge clk); #1;
      if (k == 19) start = 1'b0;
      if (done && !prev) rises++;
      if (!done && prev) falls++;
      prev = done;
    end
    check("held_rises", 32'(rises), 32'd1);
    check("held_falls", 32'(falls), 32'd1);
    check("held_product", 32'(product), 32'hD8);

    // Back-to-back operations, each showing done drop and rise
    run_op("b2b0", 8'h30, 8'h48, 8'h48);
    run_op("b2b1", 8'hB8, 8'h38, 8'hC2);

    // Asynchronous reset during MUL
    run_op("pre_reset", 8'h38, 8'h38, 8'h42);
    launch(8'h48, 8'h48);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_product", 32'(product), 32'h00);
    check("async_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("post_reset", 8'h38, 8'h38, 8'h42);

    // Randomized operands against the reference model
    for (int i = 0; i < 200; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_op($sformatf("rand%0d_%02h_%02h", i, ra, rb), ra, rb, ref_mul(ra, rb));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
